// File: rtl/imem_fetch_buffer.sv
// imem_fetch_buffer: instruction fetch stage with a small prefetch FIFO.
// Drives the memory instruction port from a fetch PC, captures the word that
// returns one cycle later and queues {pc, instruction} for decode. Redirects
// flush everything in flight so no stale word is ever delivered.
module imem_fetch_buffer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   imem_address_o,
  input  logic [31:0]                   imem_instruction_i,
  input  logic                          redirect_valid_i,
  input  logic [31:0]                   redirect_pc_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   out_pc_o,
  output logic [31:0]                   out_instruction_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_V = SUM_W'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] pc_mem_q    [FIFO_DEPTH];
  logic [31:0] instr_mem_q [FIFO_DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] credit_used;

  // Handshake decode: credit check for a new fetch, push of the returning word, pop by decode.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every output a value first,
    // so no latch can be inferred.
    credit_used = {1'b0, count_q} + SUM_W'(inflight_q);
    // A pop in the same cycle is deliberately not credited: keeps the rule simple and safe.
    issue       = !redirect_valid_i && (credit_used < DEPTH_V);
    push        = inflight_q && !redirect_valid_i;
    pop         = (count_q != '0) && out_ready_i && !redirect_valid_i;
  end

  // Next-state for fetch PC, in-flight tracker and FIFO pointers; redirect overrides everything.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect_valid_i) begin
      // The response for the current in-flight fetch arrives next cycle and is dropped
      // because inflight is cleared here.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: capture {pc, instruction} when the fetched word returns.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only observable once the count says they are valid.
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instruction_i;
    end
  end

  assign imem_address_o    = fetch_pc_q;
  assign out_valid_o       = (count_q != '0);
  assign fifo_count_o      = count_q;
  // Head outputs read zero while empty so reset presents a clean bus.
  assign out_pc_o          = out_valid_o ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign out_instruction_o = out_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Testbench for imem_fetch_buffer: table of per-cycle vectors with hand-computed
// expectations, plus a backpressure/wrap sequence checked against a PC scoreboard.
module tb_imem_fetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  imem_fetch_buffer #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_address_o     (imem_address),
    .imem_instruction_i (imem_instruction),
    .redirect_valid_i   (redirect_valid),
    .redirect_pc_i      (redirect_pc),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_pc_o           (out_pc),
    .out_instruction_o  (out_instruction),
    .fifo_count_o       (fifo_count)
  );

  always #5 clk = ~clk;

  // Memory model: word for the address seen at an edge is returned after that edge.
  always @(posedge clk) imem_instruction <= imem_address ^ XMASK;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rdv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [2:0]  exp_cnt;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rdv, input logic [31:0] rpc,
                     input logic ev, input logic [2:0] ec, input logic [31:0] ea,
                     input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.rdv = rdv; v.rpc = rpc;
    v.exp_valid = ev; v.exp_cnt = ec; v.exp_addr = ea; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    int accepted;
    logic [31:0] exp_pc;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Test 1: reset release, streaming with out_ready high.
    add(0,1,0,0, 0,0,32'h100, 0);
    add(1,1,0,0, 0,0,32'h104, 0);
    add(1,1,0,0, 1,1,32'h108, 32'h100);
    add(1,1,0,0, 1,1,32'h10C, 32'h104);
    add(1,1,0,0, 1,1,32'h110, 32'h108);
    add(1,1,0,0, 1,1,32'h114, 32'h10C);
    // Test 2: reset, then 10 cycles of backpressure, then release.
    add(0,1,0,0, 0,0,32'h100, 0);
    add(1,0,0,0, 0,0,32'h104, 0);
    add(1,0,0,0, 1,1,32'h108, 32'h100);
    add(1,0,0,0, 1,2,32'h10C, 32'h100);
    add(1,0,0,0, 1,3,32'h110, 32'h100);
    for (int k = 0; k < 6; k++) add(1,0,0,0, 1,4,32'h110, 32'h100);
    add(1,1,0,0, 1,3,32'h110, 32'h104);
    add(1,1,0,0, 1,2,32'h114, 32'h108);
    add(1,1,0,0, 1,2,32'h118, 32'h10C);
    add(1,1,0,0, 1,2,32'h11C, 32'h110);
    add(1,1,0,0, 1,2,32'h120, 32'h114);
    // Test 6: fill to full with out_ready toggling, reset one cycle, sequence restarts.
    add(1,0,0,0, 1,3,32'h124, 32'h114);
    add(1,1,0,0, 1,3,32'h124, 32'h118);
    add(1,0,0,0, 1,3,32'h128, 32'h118);
    add(1,1,0,0, 1,3,32'h128, 32'h11C);
    add(1,0,0,0, 1,3,32'h12C, 32'h11C);
    add(1,0,0,0, 1,4,32'h12C, 32'h11C);
    add(0,1,0,0, 0,0,32'h100, 0);
    add(1,1,0,0, 0,0,32'h104, 0);
    add(1,1,0,0, 1,1,32'h108, 32'h100);
    add(1,1,0,0, 1,1,32'h10C, 32'h104);
    // Test 3: redirect to 0x2003 with 3 queued entries and one fetch in flight.
    add(0,0,0,0, 0,0,32'h100, 0);
    add(1,0,0,0, 0,0,32'h104, 0);
    add(1,0,0,0, 1,1,32'h108, 32'h100);
    add(1,0,0,0, 1,2,32'h10C, 32'h100);
    add(1,0,0,0, 1,3,32'h110, 32'h100);
    add(1,0,1,32'h2003, 0,0,32'h2000, 0);
    add(1,1,0,0, 0,0,32'h2004, 0);
    add(1,1,0,0, 1,1,32'h2008, 32'h2000);
    add(1,1,0,0, 1,1,32'h200C, 32'h2004);
    // Test 4: back-to-back redirects, the last one wins.
    add(1,1,1,32'h300, 0,0,32'h300, 0);
    add(1,1,1,32'h400, 0,0,32'h400, 0);
    add(1,1,0,0, 0,0,32'h404, 0);
    add(1,1,0,0, 1,1,32'h408, 32'h400);
    add(1,1,0,0, 1,1,32'h40C, 32'h404);
    // Test 5: PC wraps through zero.
    add(1,1,1,32'hFFFF_FFF8, 0,0,32'hFFFF_FFF8, 0);
    add(1,1,0,0, 0,0,32'hFFFF_FFFC, 0);
    add(1,1,0,0, 1,1,32'h0000_0000, 32'hFFFF_FFF8);
    add(1,1,0,0, 1,1,32'h0000_0004, 32'hFFFF_FFFC);
    add(1,1,0,0, 1,1,32'h0000_0008, 32'h0000_0000);
    add(1,1,0,0, 1,1,32'h0000_000C, 32'h0000_0004);

    foreach (vecs[i]) begin
      rst_n          = vecs[i].rst_n;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d fifo_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].exp_cnt});
      check($sformatf("v%0d imem_address", i), imem_address, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d out_pc", i), out_pc, vecs[i].exp_pc);
        check($sformatf("v%0d out_instruction", i), out_instruction, vecs[i].exp_pc ^ XMASK);
      end
    end

    // Hand sequence: redirect to an unaligned PC, then drain under a ready pattern;
    // every accepted entry must be the next consecutive PC (no gap, no duplicate).
    rst_n = 1'b1; out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF1;
    @(posedge clk); #1;
    check("redir count", {29'h0, fifo_count}, 32'h0);
    check("redir address", imem_address, 32'hFFFF_FFF0);
    redirect_valid = 1'b0;
    exp_pc   = 32'hFFFF_FFF0;
    accepted = 0;
    for (int cyc = 0; cyc < 64 && accepted < 8; cyc++) begin
      out_ready = (cyc % 3) != 0;
      if (out_valid && out_ready) begin
        check($sformatf("bp pc %0d", accepted), out_pc, exp_pc);
        check($sformatf("bp instr %0d", accepted), out_instruction, exp_pc ^ XMASK);
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      @(posedge clk); #1;
      if (fifo_count > 3'd4) check("bp count bound", {29'h0, fifo_count}, 32'd4);
    end
    check("bp accepted within budget", accepted, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
